// File: rtl/sobol_sng_frame.sv
// rtl/sobol_sng_frame.sv - Sobol-driven stochastic number generator frame controller
module sobol_sng_frame #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic                iStart,
    input  logic                iBipolar,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iSobol,
    output logic                oRngEn,
    output logic                oRngClr,
    output logic                oBit,
    output logic                oValid,
    output logic                oBusy,
    output logic                oDone
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // Extra counter MSB keeps the terminal compare free of wrap-around.
    localparam logic [BITWIDTH:0] LP_LAST = {1'b0, {BITWIDTH{1'b1}}};
    localparam logic [BITWIDTH:0] LP_ONE  = {{BITWIDTH{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BITWIDTH:0]   r_cnt;
    logic [BITWIDTH-1:0] r_op;
    logic                r_bit;
    logic                r_valid;
    logic                r_done;

    logic                w_last;
    logic                w_accept;
    logic [BITWIDTH-1:0] w_op_in;

    assign w_last   = (r_cnt == LP_LAST);
    assign w_accept = (r_state == S_IDLE) && iStart && !iClr;
    // Bipolar operands become offset binary so one unsigned compare serves both modes.
    assign w_op_in  = iBipolar ? {~iData[BITWIDTH-1], iData[BITWIDTH-2:0]} : iData;

    always_comb begin
        w_state_nxt = r_state;
        oRngEn      = 1'b0;
        oRngClr     = 1'b0;
        oBusy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (iStart) w_state_nxt = S_CLR;
            end
            S_CLR: begin
                oRngClr     = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                oRngEn = 1'b1;
                if (w_last) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (iClr) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_op <= '0;
        end else if (w_accept) begin
            r_op <= w_op_in;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_cnt <= '0;
        end else if (r_state == S_CLR) begin
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + LP_ONE;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_bit   <= (r_state == S_RUN) && !iClr && (r_op > iSobol);
            r_valid <= (r_state == S_RUN) && !iClr;
            r_done  <= (r_state == S_RUN) && !iClr && w_last;
        end
    end

    assign oBit   = r_bit;
    assign oValid = r_valid;
    assign oDone  = r_done;

endmodule
